// File: rtl/arb_pkg.sv
// Shared definitions for the eight-requester arbiter.
//   N_REQ       : number of requesters
//   ID_W        : width of a requester index
//   arb_state_e : arbiter FSM states
//   onehot()    : index -> one-hot grant vector
package arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned ID_W  = 3;

  typedef enum logic [0:0] {
    IDLE,
    BUSY
  } arb_state_e;

  function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rot_priority_sel.sv
// Combinational rotating-priority winner select.
// Search order is last-1, last-2, ... wrapping modulo 8, so index `last`
// itself is searched last. With last = 0 this is plain highest-index priority.
//   req    : request vector
//   last   : previous owner (priority pointer)
//   winner : index of the selected requester (0 when none)
//   any    : at least one request is set
module rot_priority_sel
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic [ID_W-1:0]  winner,
  output logic             any
);

  logic [N_REQ-1:0] rot;
  logic [ID_W-1:0]  rot_idx;

  // rot[j] = req[j + last]; the 3-bit add wraps modulo 8.
  always_comb begin
    rot = '0;
    for (int j = 0; j < N_REQ; j++) begin
      rot[j] = req[ID_W'(j) + last];
    end
  end

  // Descending priority encode: the highest set rotated bit wins, which maps
  // back to last-1 (rot[7]), then last-2, and so on.
  always_comb begin
    rot_idx = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (rot[j]) begin
        rot_idx = ID_W'(j);
      end
    end
  end

  assign winner = rot_idx + last;
  assign any    = |req;

endmodule

// File: rtl/req_arbiter8.sv
// Eight-requester arbiter for one shared resource.
// Grants exactly one requester, holds the grant while the owner keeps
// requesting (optionally bounded by MAX_HOLD), and always inserts one idle
// arbitration cycle between ownerships. All outputs are registered.
//
// Build option ARB_ROUND_ROBIN_EN: when defined, priority rotates so the
// just-released owner ranks lowest; when undefined, fixed priority with
// index 7 highest and no pointer register.
//
// Parameters:
//   MAX_HOLD     : max consecutive granted cycles per ownership, 0 = unlimited
// Ports:
//   clk          : rising-edge clock
//   reset_n      : asynchronous active-low reset
//   req          : request vector, bit i = requester i
//   gnt          : one-hot grant, zero when idle
//   gnt_id       : index of current owner, 0 when idle
//   gnt_valid    : any grant active
//   hold_expired : one-cycle pulse on a MAX_HOLD forced release
module req_arbiter8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             hold_expired
);

  localparam int unsigned CntW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             valid_q, valid_d;
  logic             expired_q, expired_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [ID_W-1:0]  sel_last;
  logic [ID_W-1:0]  winner;
  logic             any_req;
  logic             owner_req;
  logic             limit_hit;

`ifdef ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0]  last_q, last_d;
  assign sel_last = last_q;
`else
  assign sel_last = '0;
`endif

  rot_priority_sel u_sel (
    .req    (req),
    .last   (sel_last),
    .winner (winner),
    .any    (any_req)
  );

  assign owner_req = req[id_q];
  assign limit_hit = (MAX_HOLD != 0) && (cnt_q == CntW'(MAX_HOLD));

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    id_d      = id_q;
    valid_d   = valid_q;
    expired_d = 1'b0;
    cnt_d     = cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d    = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d   = onehot(winner);
          id_d    = winner;
          valid_d = 1'b1;
          cnt_d   = CntW'(1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!owner_req || limit_hit) begin
          gnt_d     = '0;
          id_d      = '0;
          valid_d   = 1'b0;
          cnt_d     = '0;
          state_d   = IDLE;
          // A simultaneous drop at the limit is an ordinary release.
          expired_d = owner_req;
`ifdef ARB_ROUND_ROBIN_EN
          last_d    = id_q;
`endif
        end else if (cnt_q != {CntW{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      id_q      <= '0;
      valid_q   <= 1'b0;
      expired_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      id_q      <= id_d;
      valid_q   <= valid_d;
      expired_q <= expired_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= '0;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign gnt          = gnt_q;
  assign gnt_id       = id_q;
  assign gnt_valid    = valid_q;
  assign hold_expired = expired_q;

endmodule

// File: tb/tb_req_arbiter8.sv
// Scoreboard testbench for req_arbiter8. Two instances: u_dut0 with unlimited
// hold, u_dut4 with MAX_HOLD = 4. Expected outputs are queued with the cycle
// they belong to; a negedge monitor pops and compares them.
module tb_req_arbiter8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] req0 = '0;
  logic [7:0] req4 = '0;
  logic [7:0] gnt0, gnt4;
  logic [2:0] id0, id4;
  logic       v0, v4, x0, x4;

  req_arbiter8 #(.MAX_HOLD(0)) u_dut0 (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req0),
    .gnt          (gnt0),
    .gnt_id       (id0),
    .gnt_valid    (v0),
    .hold_expired (x0)
  );

  req_arbiter8 #(.MAX_HOLD(4)) u_dut4 (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req4),
    .gnt          (gnt4),
    .gnt_id       (id4),
    .gnt_valid    (v4),
    .hold_expired (x4)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned tag;
    bit          which;
    logic [12:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [12:0] outs(input bit which);
    return which ? {gnt4, id4, v4, x4} : {gnt0, id0, v0, x0};
  endfunction

  task automatic compare(input string name, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got gnt=%b id=%0d valid=%b expired=%b, want gnt=%b id=%0d valid=%b expired=%b",
               name, act[12:5], act[4:2], act[1], act[0], exp[12:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  // Drive req for one cycle and queue the outputs expected after the next edge.
  task automatic step(input bit which, input logic [7:0] r, input int id, input bit v,
                      input bit e, input string name);
    exp_t        ent;
    logic [7:0]  g;
    logic [2:0]  i3;
    @(posedge clk);
    #1;
    if (which) req4 = r; else req0 = r;
    i3 = v ? 3'(id) : 3'd0;
    g  = v ? (8'd1 << i3) : 8'd0;
    ent.tag   = cyc + 1;
    ent.which = which;
    ent.exp   = {g, i3, v, e};
    ent.name  = name;
    sb.push_back(ent);
  endtask

  task automatic do_reset(input string name);
    repeat (2) @(negedge clk);
    #1;
    reset_n = 1'b0;
    req0 = '0;
    req4 = '0;
    #1;
    compare({name, " dut0"}, outs(1'b0), 13'd0);
    compare({name, " dut4"}, outs(1'b1), 13'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
  endtask

  // Monitor: compare every queued expectation that matches the current cycle.
  initial begin
    exp_t ent;
    forever begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].tag <= cyc) begin
        ent = sb.pop_front();
        if (ent.tag != cyc) begin
          compare({ent.name, " (stale)"}, outs(ent.which), ~ent.exp);
        end else begin
          compare(ent.name, outs(ent.which), ent.exp);
        end
      end
    end
  end

  int order[9];

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    order = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
`else
    order = '{7, 7, 7, 7, 7, 7, 7, 7, 7};
`endif

    do_reset("reset");

    // Basic grant, release, idle gap, next grant.
    step(0, 8'hA0, 7, 1, 0, "basic grant 7");
    step(0, 8'h20, 0, 0, 0, "basic release idle");
    step(0, 8'h20, 5, 1, 0, "basic grant 5");
    step(0, 8'h00, 0, 0, 0, "basic release 5");
    step(0, 8'h00, 0, 0, 0, "basic stay idle");

    // All requesting, each owner holds 2 cycles, drops, re-raises.
    do_reset("reset fair");
    for (int k = 0; k < 9; k++) begin
      step(0, 8'hFF, order[k], 1, 0, $sformatf("fair grant k%0d", k));
      step(0, 8'hFF, order[k], 1, 0, $sformatf("fair hold k%0d", k));
      step(0, 8'hFF & ~(8'd1 << order[k]), 0, 0, 0, $sformatf("fair drop k%0d", k));
    end
    step(0, 8'h00, 0, 0, 0, "fair end idle");

    // Hold limit of 4, then a drop coinciding with the limit.
    do_reset("reset hold");
    step(1, 8'h04, 2, 1, 0, "hold c1");
    step(1, 8'h04, 2, 1, 0, "hold c2");
    step(1, 8'h04, 2, 1, 0, "hold c3");
    step(1, 8'h04, 2, 1, 0, "hold c4");
    step(1, 8'h04, 0, 0, 1, "hold forced release");
    step(1, 8'h04, 2, 1, 0, "hold regrant");
    step(1, 8'h04, 2, 1, 0, "hold2 c2");
    step(1, 8'h04, 2, 1, 0, "hold2 c3");
    step(1, 8'h04, 2, 1, 0, "hold2 c4");
    step(1, 8'h00, 0, 0, 0, "drop at limit no pulse");
    step(1, 8'h00, 0, 0, 0, "hold idle");

    // Non-owner churn is ignored.
    do_reset("reset churn");
    step(0, 8'h08, 3, 1, 0, "churn grant 3");
    step(0, 8'h88, 3, 1, 0, "churn r7 up");
    step(0, 8'h08, 3, 1, 0, "churn r7 down");
    step(0, 8'h88, 3, 1, 0, "churn r7 up2");
    step(0, 8'h80, 0, 0, 0, "churn release 3");
    step(0, 8'h80, 7, 1, 0, "churn grant 7");
    step(0, 8'h00, 0, 0, 0, "churn release 7");

    // Asynchronous reset mid-grant; pointer must return to 0.
    do_reset("reset async");
    step(0, 8'h40, 6, 1, 0, "async grant 6");
    step(0, 8'h00, 0, 0, 0, "async release 6");
    step(0, 8'h20, 5, 1, 0, "async grant 5");
    step(0, 8'h20, 5, 1, 0, "async hold 5");
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    compare("async clear", outs(1'b0), 13'd0);
    req0 = '0;
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    step(0, 8'hFF, 7, 1, 0, "post reset grant 7");
    step(0, 8'h00, 0, 0, 0, "post reset release");

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending, want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
